// File: rtl/tdm_demux_8to1.sv
// Receive-side 8:1 TDM demultiplexer: realigns a channel-scanned sample stream
// on its start-of-frame marker and presents each complete frame in parallel.
module tdm_demux_8to1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [WIDTH-1:0]   in_data,
  output logic [8*WIDTH-1:0] out_data,
  output logic               out_valid,
  output logic [2:0]         ch_sel,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_e;

  state_e                    state_q, state_d;
  logic [2:0]                chSel_q, chSel_d;
  logic [6:0][WIDTH-1:0]     shadow_q, shadow_d;
  logic [8*WIDTH-1:0]        outData_q, outData_d;
  logic                      outValid_q, outValid_d;
  logic                      syncErr_q, syncErr_d;
  logic                      locked_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      chSel_q    <= 3'd0;
      shadow_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      syncErr_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      chSel_q    <= chSel_d;
      shadow_q   <= shadow_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      syncErr_q  <= syncErr_d;
      locked_q   <= (state_d == COLLECT);
    end
  end

  always_comb begin
    state_d    = state_q;
    chSel_d    = chSel_q;
    shadow_d   = shadow_q;
    outData_d  = outData_q;
    outValid_d = 1'b0;
    syncErr_d  = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sof) begin
            shadow_d[0] = in_data;
            chSel_d     = 3'd1;
            state_d     = COLLECT;
          end
        end
        COLLECT: begin
          if (in_sof) begin
            // An SOF anywhere but slot 0 abandons the partial frame and restarts on it.
            syncErr_d   = (chSel_q != 3'd0);
            shadow_d[0] = in_data;
            chSel_d     = 3'd1;
          end else if (chSel_q == 3'd0) begin
            syncErr_d = 1'b1;
            state_d   = HUNT;
          end else if (chSel_q == 3'd7) begin
            outData_d  = {in_data, shadow_q};
            outValid_d = 1'b1;
            chSel_d    = 3'd0;
          end else begin
            for (int k = 1; k < 7; k++) begin
              if (chSel_q == 3'(k)) begin
                shadow_d[k] = in_data;
              end
            end
            chSel_d = chSel_q + 3'd1;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign ch_sel    = chSel_q;
  assign locked    = locked_q;
  assign sync_err  = syncErr_q;

endmodule

// File: tb/tb_tdm_demux_8to1.sv
// Scoreboard bench for tdm_demux_8to1 (WIDTH=4): expected frames and framing
// errors are queued by the stimulus and retired by an independent monitor.
module tb_tdm_demux_8to1;

  localparam int WIDTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_sof = 1'b0;
  logic [WIDTH-1:0]   in_data = '0;
  logic [8*WIDTH-1:0] out_data;
  logic               out_valid;
  logic [2:0]         ch_sel;
  logic               locked;
  logic               sync_err;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] dataQ[$];
  logic [31:0] errQ[$];

  tdm_demux_8to1 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .ch_sel   (ch_sel),
    .locked   (locked),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One beat per call; consecutive calls give back-to-back accepted samples.
  task automatic applyStimulus(input logic sof, input logic [WIDTH-1:0] data);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: retires expected frames and framing errors as the DUT presents them.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (dataQ.size() == 0) begin
          checkOutput("unexpectedOutValid", {31'd0, out_valid}, 32'd0);
        end else begin
          checkOutput("frameData", out_data, dataQ.pop_front());
        end
      end
      if (sync_err) begin
        checkOutput("errWithValid", {31'd0, out_valid}, 32'd0);
        if (errQ.size() == 0) begin
          checkOutput("unexpectedSyncErr", {31'd0, sync_err}, 32'd0);
        end else begin
          checkOutput("errOutDataHeld", out_data, errQ.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Test 1: reset state, then a back-to-back frame 1..8
    applyReset();
    checkOutput("rstOutData", out_data, 32'h0);
    checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstChSel", {29'd0, ch_sel}, 32'd0);
    checkOutput("rstLocked", {31'd0, locked}, 32'd0);
    checkOutput("rstSyncErr", {31'd0, sync_err}, 32'd0);

    // SOF without in_valid must be ignored
    @(negedge clk);
    in_sof = 1'b1;
    idle(1);
    in_sof = 1'b0;
    checkOutput("sofNoValidLocked", {31'd0, locked}, 32'd0);

    for (int k = 0; k < 8; k++) begin
      if (k == 7) dataQ.push_back(32'h87654321);
      applyStimulus(k == 0, 4'(k + 1));
    end
    checkOutput("t1OutValid", {31'd0, out_valid}, 32'd1);
    checkOutput("t1ChSel", {29'd0, ch_sel}, 32'd0);
    checkOutput("t1Locked", {31'd0, locked}, 32'd1);
    idle(1);
    checkOutput("t1ValidPulse", {31'd0, out_valid}, 32'd0);

    // Test 2: same frame with a 3-cycle gap after channel 3
    for (int k = 0; k < 4; k++) applyStimulus(k == 0, 4'(k + 1));
    for (int g = 0; g < 3; g++) begin
      idle(1);
      checkOutput("t2GapChSel", {29'd0, ch_sel}, 32'd4);
    end
    for (int k = 4; k < 8; k++) begin
      if (k == 7) dataQ.push_back(32'h87654321);
      applyStimulus(1'b0, 4'(k + 1));
    end
    checkOutput("t2OutData", out_data, 32'h87654321);

    // Test 3: hunting drops non-SOF samples silently
    applyReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'(k + 1));
      checkOutput("t3HuntChSel", {29'd0, ch_sel}, 32'd0);
    end
    checkOutput("t3HuntLocked", {31'd0, locked}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) dataQ.push_back(32'h3456789A);
      applyStimulus(k == 0, 4'(10 - k));
    end
    checkOutput("t3Locked", {31'd0, locked}, 32'd1);

    // Test 4: early SOF after 4 channels restarts the frame
    for (int k = 0; k < 4; k++) applyStimulus(k == 0, 4'(k + 1));
    errQ.push_back(32'h3456789A);
    applyStimulus(1'b1, 4'hF);
    checkOutput("t4ChSelAfterSof", {29'd0, ch_sel}, 32'd1);
    checkOutput("t4LockedAfterSof", {31'd0, locked}, 32'd1);
    for (int k = 1; k < 8; k++) begin
      if (k == 7) dataQ.push_back(32'h89ABCDEF);
      applyStimulus(1'b0, 4'(15 - k));
    end

    // Test 5: missing SOF after a complete frame drops lock
    errQ.push_back(32'h89ABCDEF);
    applyStimulus(1'b0, 4'h5);
    checkOutput("t5Locked", {31'd0, locked}, 32'd0);
    checkOutput("t5ChSel", {29'd0, ch_sel}, 32'd0);
    checkOutput("t5OutData", out_data, 32'h89ABCDEF);

    // Test 6: reset mid-frame at ch_sel=5, then a fresh frame 0..7
    for (int k = 0; k < 5; k++) applyStimulus(k == 0, 4'hC);
    checkOutput("t6PreRstChSel", {29'd0, ch_sel}, 32'd5);
    applyReset();
    checkOutput("t6RstOutData", out_data, 32'h0);
    checkOutput("t6RstChSel", {29'd0, ch_sel}, 32'd0);
    checkOutput("t6RstLocked", {31'd0, locked}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) dataQ.push_back(32'h76543210);
      applyStimulus(k == 0, 4'(k));
    end

    idle(3);
    checkOutput("dataQDrained", dataQ.size(), 32'd0);
    checkOutput("errQDrained", errQ.size(), 32'd0);
    checkOutput("finalOutData", out_data, 32'h76543210);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
